// File: rtl/rtc_bus_ctrl_if.sv
// rtc_bus_ctrl_if: request side and RTC bus side signals of the RTC bus sequencer
interface rtc_bus_ctrl_if;
    logic       wr_req;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       sweep_req;
    logic       busy;
    logic       wr_done;
    logic [3:0] reg_select;
    logic       LL_signal;
    logic       rtc_cs_n;
    logic       rtc_a_d;
    logic       rtc_rd_n;
    logic       rtc_wr_n;
    logic       rtc_oe;
    logic [7:0] rtc_ad_out;

    modport master (
        output wr_req, wr_addr, wr_data, sweep_req,
        input  busy, wr_done, reg_select, LL_signal,
        input  rtc_cs_n, rtc_a_d, rtc_rd_n, rtc_wr_n, rtc_oe, rtc_ad_out
    );

    modport slave (
        input  wr_req, wr_addr, wr_data, sweep_req,
        output busy, wr_done, reg_select, LL_signal,
        output rtc_cs_n, rtc_a_d, rtc_rd_n, rtc_wr_n, rtc_oe, rtc_ad_out
    );
endinterface

// File: rtl/rtc_bus_ctrl.sv
// rtc_bus_ctrl: sequences periodic RTC register read sweeps and interleaved writes on a multiplexed A/D bus
module rtc_bus_ctrl #(
    parameter int T_PHASE     = 4,
    parameter int REFRESH_DIV = 1000000
) (
    input  logic          clk,
    input  logic          reset,
    rtc_bus_ctrl_if.slave bus
);
    localparam int CW = (T_PHASE > 1) ? $clog2(T_PHASE) : 1;
    localparam int RW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] CNT_LOAD = CW'(T_PHASE - 1);
    localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_DIV - 1);

    typedef enum logic [2:0] {IDLE, A_SET, A_STB, A_HLD, D_SET, D_STB, D_HLD} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [RW-1:0] ref_q, ref_d;
    logic [3:0]    idx_q, idx_d;
    logic [7:0]    addr_q, addr_d;
    logic [7:0]    data_q, data_d;
    logic          wr_q, wr_d;
    logic          sweep_q, sweep_d;
    logic          pend_q, pend_d;
    logic          done_q, done_d;
    logic          busy_q, ll_q, cs_n_q, a_d_q, rd_n_q, wr_n_q, oe_q;
    logic [3:0]    sel_q;
    logic [7:0]    ad_q;
    logic          data_ph_d, oe_d;
    logic [7:0]    sweep_addr;

    // idx 0..5 map to 21..26, idx 6..8 to 41..43
    assign sweep_addr = (idx_q < 4'd6) ? 8'h21 + {4'h0, idx_q} : 8'h3B + {4'h0, idx_q};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        data_d  = data_q;
        wr_d    = wr_q;
        sweep_d = sweep_q;
        pend_d  = pend_q;
        done_d  = 1'b0;
        ref_d   = (ref_q == REF_LAST) ? '0 : ref_q + 1'b1;
        if (state_q == IDLE) begin
            // a request still high in the wr_done cycle belongs to the finished write
            if (bus.wr_req && !done_q) begin
                state_d = A_SET;
                cnt_d   = CNT_LOAD;
                wr_d    = 1'b1;
                addr_d  = bus.wr_addr;
                data_d  = bus.wr_data;
            end else if (sweep_q) begin
                state_d = A_SET;
                cnt_d   = CNT_LOAD;
                wr_d    = 1'b0;
                addr_d  = sweep_addr;
            end else if (pend_q) begin
                state_d = A_SET;
                cnt_d   = CNT_LOAD;
                wr_d    = 1'b0;
                addr_d  = 8'h21;
                idx_d   = 4'd0;
                sweep_d = 1'b1;
                pend_d  = 1'b0;
            end
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end else begin
            cnt_d   = CNT_LOAD;
            state_d = (state_q == D_HLD) ? IDLE : state_e'(state_q + 3'd1);
            if (state_q == D_HLD) begin
                done_d = wr_q;
                if (!wr_q) begin
                    idx_d   = idx_q + 4'd1;
                    sweep_d = idx_q != 4'd8;
                end
            end
        end
        if (ref_q == REF_LAST || bus.sweep_req) pend_d = 1'b1;
        data_ph_d = state_d >= D_SET;
        oe_d      = state_d != IDLE && (!data_ph_d || wr_d);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ref_q   <= '0;
            idx_q   <= 4'd0;
            addr_q  <= 8'h00;
            data_q  <= 8'h00;
            wr_q    <= 1'b0;
            sweep_q <= 1'b0;
            pend_q  <= 1'b1;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            ll_q    <= 1'b0;
            cs_n_q  <= 1'b1;
            a_d_q   <= 1'b0;
            rd_n_q  <= 1'b1;
            wr_n_q  <= 1'b1;
            oe_q    <= 1'b0;
            sel_q   <= 4'hF;
            ad_q    <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ref_q   <= ref_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            wr_q    <= wr_d;
            sweep_q <= sweep_d;
            pend_q  <= pend_d;
            done_q  <= done_d;
            busy_q  <= state_d != IDLE;
            ll_q    <= !wr_d && state_d == D_STB && cnt_d == '0;
            cs_n_q  <= state_d == IDLE;
            a_d_q   <= data_ph_d;
            rd_n_q  <= !(!wr_d && state_d == D_STB);
            wr_n_q  <= !(state_d == A_STB || (wr_d && state_d == D_STB));
            oe_q    <= oe_d;
            sel_q   <= (state_d != IDLE && !wr_d) ? idx_d : 4'hF;
            ad_q    <= !oe_d ? 8'h00 : data_ph_d ? data_d : addr_d;
        end
    end

    assign bus.busy       = busy_q;
    assign bus.wr_done    = done_q;
    assign bus.reg_select = sel_q;
    assign bus.LL_signal  = ll_q;
    assign bus.rtc_cs_n   = cs_n_q;
    assign bus.rtc_a_d    = a_d_q;
    assign bus.rtc_rd_n   = rd_n_q;
    assign bus.rtc_wr_n   = wr_n_q;
    assign bus.rtc_oe     = oe_q;
    assign bus.rtc_ad_out = ad_q;
endmodule

// File: tb/tb_rtc_bus_ctrl.sv
// tb_rtc_bus_ctrl: directed and random stimulus against a transaction-level model of the RTC bus sequencer
module tb_rtc_bus_ctrl;
    localparam int TP  = 2;
    localparam int DIV = 400;
    localparam int TXN = 6 * TP + 1;
    localparam logic [7:0] MAP [9] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h41, 8'h42, 8'h43};

    logic clk = 1'b0;
    logic reset = 1'b1;
    rtc_bus_ctrl_if bus ();

    rtc_bus_ctrl #(.T_PHASE(TP), .REFRESH_DIV(DIV)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // model: one transaction is 6*TP cycles of offset m_t, then one idle cycle
    int         m_ref, m_t, m_idx;
    bit         m_act, m_wr, m_done, m_sweep, m_pend;
    logic [7:0] m_addr, m_data;

    int         n, n0, last_busy, rdlow, bad, a_cnt, d_cnt, done_at, idle, hit, hit2, raised;
    logic       prev;
    logic [7:0] wa;
    logic [7:0] q[$];
    logic [7:0] e3 [10];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic start_txn(input bit wr, input logic [7:0] a, input logic [7:0] d);
        m_act  = 1'b1;
        m_t    = 0;
        m_wr   = wr;
        m_addr = a;
        m_data = d;
    endtask

    task automatic model_step();
        bit set;
        if (reset) begin
            m_ref = 0; m_t = 0; m_idx = 0;
            m_act = 0; m_wr = 0; m_done = 0; m_sweep = 0; m_pend = 1;
            return;
        end
        set   = (m_ref == DIV - 1) || bus.sweep_req;
        m_ref = (m_ref == DIV - 1) ? 0 : m_ref + 1;
        if (m_act) begin
            if (m_t == 6 * TP - 1) begin
                m_act  = 0;
                m_done = m_wr;
                if (!m_wr) begin
                    m_idx++;
                    if (m_idx == 9) m_sweep = 0;
                end
            end else begin
                m_t++;
                m_done = 0;
            end
        end else begin
            if (bus.wr_req && !m_done) start_txn(1, bus.wr_addr, bus.wr_data);
            else if (m_sweep) start_txn(0, MAP[m_idx], 8'h00);
            else if (m_pend) begin
                m_sweep = 1;
                m_idx   = 0;
                m_pend  = 0;
                start_txn(0, MAP[0], 8'h00);
            end
            m_done = 0;
        end
        if (set) m_pend = 1;
    endtask

    task automatic tick();
        int ph;
        logic [11:0] ev, gv;
        model_step();
        @(negedge clk);
        ph = m_t / TP;
        ev = {m_act, m_done, (m_act && !m_wr) ? 4'(m_idx) : 4'hF,
              m_act && !m_wr && ph == 4 && (m_t % TP) == TP - 1,
              !m_act, m_act && ph >= 3, !(m_act && !m_wr && ph == 4),
              !(m_act && (ph == 1 || (m_wr && ph == 4))), m_act && (ph < 3 || m_wr)};
        gv = {bus.busy, bus.wr_done, bus.reg_select, bus.LL_signal, bus.rtc_cs_n,
              bus.rtc_a_d, bus.rtc_rd_n, bus.rtc_wr_n, bus.rtc_oe};
        chk("bus", gv, ev);
        if (ev[0]) chk("ad", bus.rtc_ad_out, ph < 3 ? m_addr : m_data);
    endtask

    initial begin
        bus.wr_req = 0; bus.wr_addr = 0; bus.wr_data = 0; bus.sweep_req = 0;
        repeat (3) tick();
        chk("rst_cs_n", bus.rtc_cs_n, 1);
        chk("rst_rd_wr", {bus.rtc_rd_n, bus.rtc_wr_n}, 2'b11);
        chk("rst_oe_ll", {bus.rtc_oe, bus.LL_signal, bus.rtc_a_d}, 3'b000);
        chk("rst_sel", bus.reg_select, 4'hF);
        chk("rst_busy", {bus.busy, bus.wr_done}, 2'b00);
        // post-reset sweep
        reset = 0;
        n = 0; last_busy = -1; rdlow = 0; bad = 0;
        for (int k = 1; k <= 130; k++) begin
            tick();
            if (bus.busy) last_busy = k;
            if (!bus.rtc_rd_n) rdlow++;
            if (bus.rtc_a_d && (bus.rtc_oe || !bus.rtc_wr_n)) bad++;
            if (bus.LL_signal) begin
                chk("t1_ll_sel", bus.reg_select, n);
                chk("t1_ll_cyc", k, 5 * TP + TXN * n);
                chk("t1_ll_rd", bus.rtc_rd_n, 0);
                n++;
            end
        end
        chk("t1_ll_cnt", n, 9);
        chk("t1_busy_end", last_busy, 9 * TXN - 1);
        chk("t6_rd_low", rdlow, 9 * TP);
        chk("t6_dphase", bad, 0);
        // single write while idle; late input changes must be ignored
        bus.wr_req = 1; bus.wr_addr = 8'h22; bus.wr_data = 8'h59;
        n = 0; a_cnt = 0; d_cnt = 0; done_at = -1;
        for (int k = 1; k <= 20 && done_at < 0; k++) begin
            tick();
            if (k == 2) begin bus.wr_addr = 8'hAA; bus.wr_data = 8'h55; end
            if (!bus.rtc_wr_n && !bus.rtc_a_d && bus.rtc_ad_out == 8'h22) a_cnt++;
            if (!bus.rtc_wr_n && bus.rtc_a_d && bus.rtc_ad_out == 8'h59) d_cnt++;
            if (bus.LL_signal) n++;
            if (bus.wr_done) begin done_at = k; bus.wr_req = 0; end
        end
        chk("t2_a_stb", a_cnt, TP);
        chk("t2_d_stb", d_cnt, TP);
        chk("t2_ll", n, 0);
        chk("t2_done_at", done_at, TXN);
        tick(); tick();
        // write inserted during idx 3 read
        wa = 8'($urandom);
        e3 = '{8'h21, 8'h22, 8'h23, 8'h24, wa, 8'h25, 8'h26, 8'h41, 8'h42, 8'h43};
        bus.sweep_req = 1; q.delete(); prev = 1; idle = 0; raised = 0;
        for (int k = 0; k < 400 && idle < 2; k++) begin
            tick();
            bus.sweep_req = 0;
            if (!raised && bus.reg_select == 4'd3) begin
                raised = 1; bus.wr_req = 1; bus.wr_addr = wa; bus.wr_data = 8'($urandom);
            end
            if (bus.wr_done) bus.wr_req = 0;
            if (!bus.rtc_wr_n && prev && !bus.rtc_a_d) q.push_back(bus.rtc_ad_out);
            prev = bus.rtc_wr_n;
            idle = bus.busy ? 0 : idle + 1;
        end
        chk("t3_ntx", q.size(), 10);
        for (int i = 0; i < 10 && i < q.size(); i++) chk("t3_addr", q[i], e3[i]);
        // sweep spanning the refresh wrap with two extra requests
        for (int k = 0; k < DIV && m_ref != DIV - 60; k++) tick();
        bus.sweep_req = 1; n = 0; n0 = 0; idle = 0;
        for (int k = 0; k < 600 && idle < 2; k++) begin
            tick();
            bus.sweep_req = (k == 20 || k == 70);
            if (bus.LL_signal) begin n++; if (bus.reg_select == 4'd0) n0++; end
            idle = bus.busy ? 0 : idle + 1;
        end
        chk("t4_ll", n, 18);
        chk("t4_sweeps", n0, 2);
        // reset during write data strobe
        bus.wr_req = 1; bus.wr_addr = 8'($urandom); bus.wr_data = 8'($urandom); hit = 0;
        for (int k = 0; k < 40 && !hit; k++) begin
            tick();
            if (!bus.rtc_wr_n && bus.rtc_a_d) hit = 1;
        end
        chk("t5_dstb", hit, 1);
        reset = 1; bus.wr_req = 0;
        tick();
        chk("t5_cs_wr", {bus.rtc_cs_n, bus.rtc_wr_n}, 2'b11);
        chk("t5_oe_done", {bus.rtc_oe, bus.wr_done}, 2'b00);
        tick();
        reset = 0; hit = 0; hit2 = 0;
        for (int k = 0; k < 60 && !hit2; k++) begin
            tick();
            if (!hit && !bus.rtc_wr_n) begin hit = 1; chk("t5_addr", bus.rtc_ad_out, 8'h21); end
            if (bus.LL_signal) begin hit2 = 1; chk("t5_sel", bus.reg_select, 0); end
        end
        chk("t5_ll", hit2, 1);
        // random traffic
        for (int k = 0; k < 1500; k++) begin
            tick();
            bus.sweep_req = ($urandom_range(0, 149) == 0);
            bus.wr_addr = 8'($urandom);
            bus.wr_data = 8'($urandom);
            if (reset) reset = ($urandom_range(0, 2) == 0);
            else if ($urandom_range(0, 499) == 0) begin reset = 1; bus.wr_req = 0; end
            else if (bus.wr_req) begin
                if (bus.wr_done && $urandom_range(0, 3) != 0) bus.wr_req = 0;
            end
            else bus.wr_req = ($urandom_range(0, 19) == 0);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
